// File: rtl/uart_cpld_port.sv
`default_nettype none
// ============================================================================
// Module  : uart_cpld_port
// Brief   : ThinPad-style byte UART on the shared RAM1 low data byte.
//           It uses rdn/wrn strobes and polled data_ready/tbre/tsre flags.
// Revision: 1.0 - initial release
// ============================================================================
module uart_cpld_port #(
    parameter int BAUD_DIV = 96,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] data,
    input  logic       rdn,
    input  logic       wrn,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd,
    output logic       overrun,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    logic r_rdn_m, r_rdn_s, r_rdn_d;
    logic r_wrn_m, r_wrn_s, r_wrn_d;
    logic r_rxd_m, r_rxd_s, r_rxd_d;
    logic r_conflict;
    logic [7:0] r_stage, r_thr, r_rbr;

    logic w_rd_rise, w_wr_rise, w_both_low, w_wr_commit, w_rd_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdn_m <= 1'b1;
            r_rdn_s <= 1'b1;
            r_rdn_d <= 1'b1;
            r_wrn_m <= 1'b1;
            r_wrn_s <= 1'b1;
            r_wrn_d <= 1'b1;
            r_rxd_m <= 1'b1;
            r_rxd_s <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_rdn_m <= rdn;
            r_rdn_s <= r_rdn_m;
            r_rdn_d <= r_rdn_s;
            r_wrn_m <= wrn;
            r_wrn_s <= r_wrn_m;
            r_wrn_d <= r_wrn_s;
            r_rxd_m <= rxd;
            r_rxd_s <= r_rxd_m;
            r_rxd_d <= r_rxd_s;
        end
    end

    assign w_rd_rise   = r_rdn_s & ~r_rdn_d;
    assign w_wr_rise   = r_wrn_s & ~r_wrn_d;
    assign w_both_low  = ~r_rdn_s & ~r_wrn_s;
    // A strobe pair that overlapped low is dropped when it releases.
    assign w_wr_commit = w_wr_rise & ~r_conflict;
    assign w_rd_clear  = w_rd_rise & ~r_conflict;

    assign data = (!rdn && wrn) ? r_rbr : 8'hzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage    <= 8'h00;
            r_thr      <= 8'h00;
            r_conflict <= 1'b0;
        end else begin
            if (!r_wrn_s) begin
                r_stage <= data;
            end
            if (w_wr_commit) begin
                r_thr <= r_stage;
            end
            if (w_both_low) begin
                r_conflict <= 1'b1;
            end else if (r_rdn_s && r_wrn_s && r_rdn_d && r_wrn_d) begin
                r_conflict <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- TX
    uart_state_t      r_tx_state, w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_bit, w_tx_bit_nxt;
    logic [7:0]       r_tx_shift, w_tx_shift_nxt;
    logic             r_tbre, w_tbre_nxt;
    logic             r_tsre, w_tsre_nxt;
    logic             r_txd, w_txd_nxt;
    logic             w_tx_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tbre     <= 1'b1;
            r_tsre     <= 1'b1;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tbre     <= w_tbre_nxt;
            r_tsre     <= w_tsre_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tbre_nxt     = r_tbre;
        w_tsre_nxt     = r_tsre;
        w_txd_nxt      = r_txd;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_tx_load    = ~r_tbre;
            end
            ST_START: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = 3'd0;
                    w_txd_nxt      = r_tx_shift[0];
                    w_tx_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_txd_nxt      = 1'b1;
                        w_tx_state_nxt = ST_STOP;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_txd_nxt      = r_tx_shift[1];
                    end
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (!r_tbre) begin
                        w_tx_load = 1'b1;
                    end else begin
                        w_tsre_nxt     = 1'b1;
                        w_tx_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_tx_state_nxt = ST_IDLE;
        endcase
        if (w_tx_load) begin
            w_tx_shift_nxt = r_thr;
            w_tbre_nxt     = 1'b1;
            w_tsre_nxt     = 1'b0;
            w_txd_nxt      = 1'b0;
            w_tx_cnt_nxt   = '0;
            w_tx_state_nxt = ST_START;
        end
        // A fresh write outranks a simultaneous load so the new byte is not lost.
        if (w_wr_commit) begin
            w_tbre_nxt = 1'b0;
        end
    end

    // ---------------------------------------------------------------- RX
    uart_state_t      r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]       r_rx_bit, w_rx_bit_nxt;
    logic [7:0]       r_rx_shift, w_rx_shift_nxt;
    logic             r_data_ready, r_overrun, r_frame_err;
    logic             w_rx_commit, w_rx_ferr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state   <= ST_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_rbr        <= 8'h00;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_rx_bit     <= w_rx_bit_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            r_overrun    <= w_rx_commit & r_data_ready & ~w_rd_clear;
            r_frame_err  <= w_rx_ferr;
            if (w_rx_commit) begin
                r_rbr        <= r_rx_shift;
                r_data_ready <= 1'b1;
            end else if (w_rd_clear) begin
                r_data_ready <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_commit    = 1'b0;
        w_rx_ferr      = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (r_rxd_d && !r_rxd_s) begin
                    w_rx_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_bit_nxt   = 3'd0;
                    w_rx_state_nxt = r_rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rxd_s, r_rx_shift[7:1]};
                    w_rx_bit_nxt   = r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = ST_IDLE;
                    w_rx_commit    = r_rxd_s;
                    w_rx_ferr      = ~r_rxd_s;
                end
            end
            default: w_rx_state_nxt = ST_IDLE;
        endcase
    end

    assign data_ready = r_data_ready;
    assign tbre       = r_tbre;
    assign tsre       = r_tsre;
    assign txd        = r_txd;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cpld_port.sv
`default_nettype none
// Directed bench for uart_cpld_port: stimulus pushes expected bytes/events into
// queues that independent TX-line, bus-read and status-pulse monitors drain.
module tb_uart_cpld_port;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rdn = 1'b1;
    logic       wrn = 1'b1;
    logic       rxd = 1'b1;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dout = 8'h00;
    wire  [7:0] data;
    logic       data_ready, tbre, tsre, txd, overrun, frame_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] evt_q[$];   // 0 = overrun, 1 = frame_err

    assign data = tb_oe ? tb_dout : 8'hzz;

    uart_cpld_port #(.BAUD_DIV(BD), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .rdn        (rdn),
        .wrn        (wrn),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .txd        (txd),
        .rxd        (rxd),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    // ---------------------------------------------------------- monitors
    logic [7:0] tm_byte;
    logic       tm_stop;
    bit         tm_abort;

    initial begin : tx_monitor
        forever begin
            @(negedge clk);
            if (rst && txd == 1'b0) begin
                tm_abort = 1'b0;
                repeat (BD / 2) @(negedge clk);
                if (!rst) tm_abort = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    if (!rst) tm_abort = 1'b1;
                    tm_byte[i] = txd;
                end
                repeat (BD) @(negedge clk);
                if (!rst) tm_abort = 1'b1;
                tm_stop = txd;
                if (!tm_abort) begin
                    if (tx_q.size() == 0) unexpected("tx_frame", tm_byte);
                    else check("tx_byte", tm_byte, tx_q.pop_front());
                    check("tx_stop_bit", tm_stop, 1);
                end
            end
        end
    end

    initial begin : read_monitor
        forever begin
            @(negedge rdn);
            #1;
            if (wrn) begin
                if (rd_q.size() == 0) unexpected("bus_read", data);
                else check("bus_read", data, rd_q.pop_front());
            end
        end
    end

    initial begin : status_monitor
        forever begin
            @(negedge clk);
            if (overrun) begin
                if (evt_q.size() == 0) unexpected("overrun_pulse", 0);
                else check("status_pulse_kind", 0, evt_q.pop_front());
            end
            if (frame_err) begin
                if (evt_q.size() == 0) unexpected("frame_err_pulse", 1);
                else check("status_pulse_kind", 1, evt_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- stimulus
    task automatic cpu_write(input logic [7:0] b, output int tbre_low, output int t_start);
        @(negedge clk);
        tb_dout = b;
        tb_oe   = 1'b1;
        wrn     = 1'b0;
        repeat (3) @(negedge clk);
        wrn      = 1'b1;
        tbre_low = 0;
        t_start  = -1;
        repeat (8) begin
            @(negedge clk);
            if (!tbre) tbre_low++;
            if (!txd && t_start < 0) t_start = cyc;
        end
        tb_oe = 1'b0;
    endtask

    task automatic wait_tsre(input int t0, output int len);
        len = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tsre) begin
                len = cyc - t0;
                break;
            end
        end
    endtask

    task automatic cpu_read(input logic [7:0] exp);
        rd_q.push_back(exp);
        @(negedge clk);
        rdn = 1'b0;
        repeat (3) @(negedge clk);
        rdn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, output logic dr_before);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BD) @(negedge clk);
        end
        dr_before = data_ready;
        rxd = stop;
        repeat (BD) @(negedge clk);
        rxd = 1'b1;
    endtask

    int   lo, t0, tdummy, len, lows;
    logic drb;

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_data_ready", data_ready, 0);
        check("rst_tbre", tbre, 1);
        check("rst_tsre", tsre, 1);
        check("rst_txd", txd, 1);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte 0xA5: frame 0,1,0,1,0,0,1,0,1,1
        tx_q.push_back(8'hA5);
        cpu_write(8'hA5, lo, t0);
        check("a5_tbre_low_cycles", lo, 1);
        wait_tsre(t0, len);
        check("a5_tsre_delay", len, 160);
        repeat (10) @(negedge clk);

        // Back-to-back 0x11 then 0x22
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        cpu_write(8'h11, lo, t0);
        check("b2b_tbre_low_cycles", lo, 1);
        repeat (40) @(negedge clk);
        cpu_write(8'h22, lo, tdummy);
        check("b2b_tbre_pending", tbre, 0);
        wait_tsre(t0, len);
        check("b2b_tsre_delay", len, 320);
        repeat (10) @(negedge clk);

        // Receive 0x3C and read it back
        rx_send(8'h3C, 1'b1, drb);
        check("rx3c_ready_before_stop", drb, 0);
        check("rx3c_ready_after_stop", data_ready, 1);
        cpu_read(8'h3C);
        check("rx3c_ready_after_read", data_ready, 0);
        tb_dout = 8'h00;
        tb_oe   = 1'b1;
        @(negedge clk);
        check("bus_released", data, 8'h00);
        tb_oe = 1'b0;

        // Short glitch on rxd
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_ready", data_ready, 0);

        // Overrun: 0x01 then 0x02 unread
        evt_q.push_back(8'd0);
        rx_send(8'h01, 1'b1, drb);
        check("rx01_ready_before_stop", drb, 0);
        rx_send(8'h02, 1'b1, drb);
        check("rx02_ready_before_stop", drb, 1);
        check("rx02_ready_after", data_ready, 1);

        // Framing error keeps RBR and data_ready
        evt_q.push_back(8'd1);
        rx_send(8'h55, 1'b0, drb);
        repeat (20) @(negedge clk);
        check("ferr_ready_unchanged", data_ready, 1);

        // Both strobes low together: no write, no read clear
        @(negedge clk);
        rdn = 1'b0;
        wrn = 1'b0;
        repeat (4) @(negedge clk);
        rdn = 1'b1;
        wrn = 1'b1;
        repeat (8) @(negedge clk);
        check("both_low_ready_kept", data_ready, 1);
        check("both_low_no_write", tbre, 1);

        cpu_read(8'h02);
        check("rx02_ready_after_read", data_ready, 0);

        // Reset in the middle of a transmitted frame
        cpu_write(8'h00, lo, t0);
        repeat (40) @(negedge clk);
        check("midframe_txd_low", txd, 0);
        rst = 1'b0;
        #1;
        check("midframe_rst_txd", txd, 1);
        check("midframe_rst_tsre", tsre, 1);
        check("midframe_rst_tbre", tbre, 1);
        repeat (20) @(negedge clk);
        rst  = 1'b1;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!txd) lows++;
        end
        check("no_resume_txd_lows", lows, 0);
        check("no_resume_tsre", tsre, 1);

        repeat (20) @(negedge clk);
        check("tx_queue_drained", tx_q.size(), 0);
        check("rd_queue_drained", rd_q.size(), 0);
        check("evt_queue_drained", evt_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cpld_port.md
Name: uart_cpld_port

Overview:
- Device-side model and synthesizable implementation of the ThinPad on-board UART that the CPU memory module talks to via rdn/wrn/data_ready/tbre/tsre over the shared low byte of the RAM1 data bus.
- Serializes bytes written by the CPU onto txd, deserializes rxd into a one-byte receive buffer, and drives the status flags that the CPU polls.
- Used as the simulation responder for the memory module and as the FPGA-side replacement for the CPLD UART.

Parameters:
- BAUD_DIV, 96: clk cycles per serial bit. 11.0592 MHz / 115200 baud. Must be even and >= 8.
- CNT_W, 8: width of the baud counters. Must satisfy 2^CNT_W > BAUD_DIV.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- data  inout  8  shared bus (RAM1 data[7:0]); high-Z unless this block is driving a read.
- rdn  input  1  read strobe from CPU, active-low.
- wrn  input  1  write strobe from CPU, active-low.
- data_ready  output  1  receive buffer holds an unread byte.
- tbre  output  1  transmit holding register empty.
- tsre  output  1  transmit shift register empty (line idle).
- txd  output  1  serial transmit line; idle high.
- rxd  input  1  serial receive line; asynchronous.
- overrun  output  1  one-cycle pulse: received byte overwrote an unread byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values (async, rst==0): data_ready=0, tbre=1, tsre=1, txd=1, overrun=0, frame_err=0, bus high-Z, all FSMs IDLE, counters 0, THR=RBR=0.
- Reset mid-frame aborts the frame immediately; txd returns to 1 in the same reset assertion, with no partial stop bit.
- Synchronization:
  - rdn, wrn and rxd each pass through 2-flop synchronizers (rdn_s, wrn_s, rxd_s).
  - Edges are detected on the synchronized versions.
- Bus drive:
  - data = RBR when raw rdn==0 and raw wrn==1; otherwise high-Z.
  - The output enable is combinational from the pins, so data is valid within the same CPU clock phase.
- Write path:
  - While wrn_s==0, a staging register captures data every cycle.
  - On the rising edge of wrn_s: THR <= staged value; tbre <= 0 on the next clk.
  - A write while tbre==0 overwrites THR; the old byte is lost and no flag is raised.
- Read path:
  - On the rising edge of rdn_s: data_ready <= 0.
  - A read while data_ready==0 returns the stale RBR.
- Both rdn_s and wrn_s low in the same cycle is illegal: the write is not committed, the bus is not driven, and data_ready is unchanged.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if tbre==0, load shifter <= THR, set tbre <= 1, tsre <= 0, txd <= 0, go to START.
  - START: after BAUD_DIV cycles, go to DATA. txd = shifter[0].
  - DATA: 8 bits, LSB first, each held BAUD_DIV cycles. Bit counter 0..7; after bit 7, txd <= 1 and go to STOP.
  - STOP: held BAUD_DIV cycles. At the end, if tbre==0, load the next byte back-to-back (no extra idle cycle, tsre stays 0). Otherwise tsre <= 1 and go to IDLE.
  - Frame length is exactly 10*BAUD_DIV clks. tbre rises 1 cycle after the load; tsre rises 10*BAUD_DIV cycles after the start bit begins.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge on rxd_s goes to START with count 0.
  - START: at count BAUD_DIV/2-1, sample. If rxd_s==1 it is a false start, so return to IDLE. Otherwise reset the count and go to DATA.
  - DATA: sample at each BAUD_DIV boundary (mid-bit) and shift in LSB first; 8 samples.
  - STOP: sample at mid-bit.
    - If 1: RBR <= byte, data_ready <= 1. If data_ready was already 1, pulse overrun.
    - If 0: discard the byte and pulse frame_err; data_ready is unchanged.
    - Either way, return to IDLE. The next falling edge is accepted from the cycle after the stop sample.
- Simultaneous RX commit and rdn_s rising edge: the new byte wins, data_ready stays 1, and no overrun is reported.
- TX and RX are fully independent; loopback (txd tied to rxd) must work at any BAUD_DIV.

Test Plan:
- Reset then release:
  - Required: data_ready=0, tbre=1, tsre=1, txd=1, data high-Z.
  - Assert rst low mid-TX frame: txd=1 immediately and the frame does not resume.
- BAUD_DIV=16, CPU writes 0xA5 (wrn low 3 clks):
  - tbre=0 for 1 cycle after the wrn edge, then 1.
  - txd sequence 0,1,0,1,0,0,1,0,1,1, each 16 clks.
  - tsre=1 exactly 160 clks after the start bit.
- Two writes 0x11 then 0x22, the second issued while 0x11 is shifting: two contiguous 160-clk frames with no idle gap; tsre stays 0 throughout.
- Drive rxd with the frame for 0x3C:
  - data_ready=1 after the stop-bit mid-sample.
  - Pulse rdn low: data=0x3C while rdn low; data_ready=0 after the rdn rise.
- rxd glitch low for 4 clks: no byte received and data_ready stays 0.
- Two RX frames (0x01, 0x02) without a read:
  - overrun pulses once; RBR=0x02.
  - Frame with stop bit 0: frame_err pulses and RBR is unchanged.
